// File: rtl/bcd_calc_front.sv
// Operand entry, key debouncing and BCD add/subtract front end for the 7-segment scanner.
// Optional SHOW auto-clear is enabled by defining BCD_CALC_TIMEOUT_EN.
module bcd_calc_front #(
  parameter int unsigned DEB_CYC     = 250000,
  parameter int unsigned TIMEOUT_CYC = 25000000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       op_sub,
  input  logic       key_ent,
  input  logic       key_go,
  input  logic       key_clr,
  output logic [3:0] tens_bcd,
  output logic [3:0] ones_bcd,
  output logic       minus_out,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  typedef enum logic [2:0] {IDLE, GOT_A, GOT_B, CALC1, CALC2, SHOW} state_t;

  // Key vectors: bit 0 = ent, bit 1 = go, bit 2 = clr
  logic [2:0]    raw, s1, s2, acc, acc_d, pulse;
  logic [CW-1:0] cnt [3];

  assign raw = {key_clr, key_go, key_ent};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      acc   <= '0;
      acc_d <= '0;
      pulse <= '0;
      for (int unsigned k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      acc_d <= acc;
      pulse <= acc & ~acc_d;
      // A sample matching the accepted level restarts the run of new-level samples
      for (int unsigned k = 0; k < 3; k++) begin
        if (s2[k] == acc[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DEB_LAST) begin
          acc[k] <= s2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  logic ent_p, go_p, clr_p;
  assign ent_p = pulse[0];
  assign go_p  = pulse[1];
  assign clr_p = pulse[2];

  state_t     state, state_n;
  logic [3:0] a, a_n, b, b_n;
  logic       sub, sub_n;
  logic [5:0] r, r_n, mag;
  logic [3:0] tens_n, ones_n;
  logic       minus_n, err_n, din_ok;

`ifdef BCD_CALC_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo, tmo_n;
`endif

  assign din_ok = (din <= 4'd9);
  assign busy   = (state == CALC1) || (state == CALC2);

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    sub_n   = sub;
    r_n     = r;
    tens_n  = tens_bcd;
    ones_n  = ones_bcd;
    minus_n = minus_out;
    err_n   = 1'b0;
    mag     = '0;
`ifdef BCD_CALC_TIMEOUT_EN
    tmo_n   = '0;
`endif
    if (clr_p) begin
      state_n = IDLE;
      a_n     = '0;
      b_n     = '0;
      sub_n   = 1'b0;
      r_n     = '0;
      tens_n  = '0;
      ones_n  = '0;
      minus_n = 1'b0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (ent_p) begin
            if (din_ok) begin
              a_n     = din;
              tens_n  = '0;
              ones_n  = din;
              minus_n = 1'b0;
              state_n = GOT_A;
            end else begin
              err_n = 1'b0 | 1'b1;
            end
          end
`ifdef BCD_CALC_TIMEOUT_EN
          // Any pulse restarts the idle count; expiry behaves like a clear
          if (state == SHOW && !(ent_p || go_p)) begin
            if (tmo == TW'(TIMEOUT_CYC - 1)) begin
              state_n = IDLE;
              a_n     = '0;
              b_n     = '0;
              tens_n  = '0;
              ones_n  = '0;
              minus_n = 1'b0;
            end else begin
              tmo_n = tmo + 1'b1;
            end
          end
`endif
        end
        GOT_A, GOT_B: begin
          if (ent_p) begin
            if (din_ok) begin
              b_n     = din;
              ones_n  = din;
              state_n = GOT_B;
            end else begin
              err_n = 1'b1;
            end
          end else if (go_p && state == GOT_B) begin
            sub_n   = op_sub;
            state_n = CALC1;
          end
        end
        CALC1: begin
          r_n     = sub ? ({2'b00, a} - {2'b00, b}) : ({2'b00, a} + {2'b00, b});
          state_n = CALC2;
        end
        CALC2: begin
          mag     = r[5] ? (~r + 6'd1) : r;
          tens_n  = (mag >= 6'd10) ? 4'd1 : 4'd0;
          ones_n  = 4'((mag >= 6'd10) ? (mag - 6'd10) : mag);
          minus_n = r[5];
          state_n = SHOW;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      sub       <= 1'b0;
      r         <= '0;
      tens_bcd  <= '0;
      ones_bcd  <= '0;
      minus_out <= 1'b0;
      err       <= 1'b0;
`ifdef BCD_CALC_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      state     <= state_n;
      a         <= a_n;
      b         <= b_n;
      sub       <= sub_n;
      r         <= r_n;
      tens_bcd  <= tens_n;
      ones_bcd  <= ones_n;
      minus_out <= minus_n;
      err       <= err_n;
`ifdef BCD_CALC_TIMEOUT_EN
      tmo       <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_calc_front.sv
// Randomized scoreboard bench for bcd_calc_front; expected outputs come from a cycle-stamped
// behavioural model of the calculator. Define BCD_CALC_TIMEOUT_EN to exercise auto-clear.
module tb_bcd_calc_front;
  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 50;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       op_sub, key_ent, key_go, key_clr;
  logic [3:0] tens_bcd, ones_bcd;
  logic       minus_out, busy, err;

  bcd_calc_front #(.DEB_CYC(DEB), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .rst(rst), .din(din), .op_sub(op_sub),
    .key_ent(key_ent), .key_go(key_go), .key_clr(key_clr),
    .tens_bcd(tens_bcd), .ones_bcd(ones_bcd), .minus_out(minus_out),
    .busy(busy), .err(err)
  );

  always #20 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] tens, ones;
    logic       minus, bsy, er;
    string      name;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  // Model: stage 0 empty, 1 holding a, 2 holding a and b, 3 showing a result
  int   m_stage = 0, m_a = 0, m_b = 0, m_tens = 0, m_ones = 0;
  logic m_minus = 1'b0;
  int   show_ref = 0;
  int   last_show = 0;

  task automatic expect_at(input int at, input logic bsy, input logic er, input string nm);
    exp_t e;
    e.at = at; e.tens = 4'(m_tens); e.ones = 4'(m_ones); e.minus = m_minus;
    e.bsy = bsy; e.er = er; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic m_zero();
    m_stage = 0; m_a = 0; m_b = 0; m_tens = 0; m_ones = 0; m_minus = 1'b0;
  endtask

  // Ages a shown result up to the pulse cycle p (auto-clear only exists with the macro)
  task automatic m_age(input int p);
`ifdef BCD_CALC_TIMEOUT_EN
    if (m_stage == 3 && show_ref + int'(TMO) <= p) m_zero();
`else
    if (p < 0) m_zero();
`endif
  endtask

  task automatic m_ent(input int c, input int d);
    int p = c + DEB + 3;
    m_age(p);
    if (d > 9) begin
      if (m_stage == 3) show_ref = p + 1;
      expect_at(p + 1, 1'b0, 1'b1, "ent_bad_err");
      expect_at(p + 2, 1'b0, 1'b0, "ent_bad_once");
      return;
    end
    case (m_stage)
      0, 3: begin m_a = d; m_stage = 1; m_tens = 0; m_ones = d; m_minus = 1'b0; end
      default: begin m_b = d; m_stage = 2; m_ones = d; end
    endcase
    expect_at(p + 1, 1'b0, 1'b0, "ent");
  endtask

  task automatic m_go(input int c, input logic sub);
    int p = c + DEB + 3;
    int r, mag;
    m_age(p);
    if (m_stage != 2) begin
      if (m_stage == 3) show_ref = p + 1;
      expect_at(p + 3, 1'b0, 1'b0, "go_ignored");
      return;
    end
    expect_at(p + 1, 1'b1, 1'b0, "calc1_hold");
    expect_at(p + 2, 1'b1, 1'b0, "calc2_hold");
    r = sub ? (m_a - m_b) : (m_a + m_b);
    mag = (r < 0) ? -r : r;
    m_tens = mag / 10; m_ones = mag % 10; m_minus = (r < 0);
    m_stage = 3; show_ref = p + 3; last_show = p + 3;
    expect_at(p + 3, 1'b0, 1'b0, "result");
  endtask

  task automatic m_clr(input int c);
    m_zero();
    expect_at(c + DEB + 4, 1'b0, 1'b0, "clear");
  endtask

  task automatic press(input logic [2:0] m, output int c);
    @(posedge clk_sys); #1;
    c = cyc;
    {key_clr, key_go, key_ent} = m;
  endtask

  task automatic finish_press();
    repeat (DEB + 5) @(posedge clk_sys);
    #1 {key_clr, key_go, key_ent} = 3'b000;
    repeat (DEB + 7) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_ent(input int d);
    int c;
    din = 4'(d);
    press(3'b001, c); m_ent(c, d); finish_press();
  endtask

  task automatic do_go(input logic sub);
    int c;
    op_sub = sub;
    press(3'b010, c); m_go(c, sub); finish_press();
  endtask

  task automatic do_clr();
    int c;
    press(3'b100, c); m_clr(c); finish_press();
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.at < cyc) begin
        fails++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.at, cyc);
      end else if ({tens_bcd, ones_bcd, minus_out, busy, err} !== {e.tens, e.ones, e.minus, e.bsy, e.er}) begin
        fails++;
        $display("FAIL %s @%0d: got tens=%0d ones=%0d minus=%0b busy=%0b err=%0b, want tens=%0d ones=%0d minus=%0b busy=%0b err=%0b",
                 e.name, cyc, tens_bcd, ones_bcd, minus_out, busy, err,
                 e.tens, e.ones, e.minus, e.bsy, e.er);
      end
    end
  end

  initial begin
    int c, k;
    rst = 1'b1; din = '0; op_sub = 1'b0;
    {key_clr, key_go, key_ent} = 3'b000;
    @(posedge clk_sys); #1;
    expect_at(cyc + 1, 1'b0, 1'b0, "reset");
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

    do_ent(5); do_ent(2); do_go(1'b0);
    do_ent(9); do_ent(9); do_go(1'b0);
    do_ent(3); do_ent(7); do_go(1'b1);
    do_ent(0); do_ent(0); do_go(1'b1);

    do_clr();
    do_ent(12);

    // Chatter then a steady press: exactly one pulse leaves a GOT_A-like state, so go is ignored
    din = 4'd4;
    for (int i = 0; i < 10; i++) begin
      key_ent = (i % 2 == 0);
      repeat (2) @(posedge clk_sys);
      #1;
    end
    press(3'b001, c); m_ent(c, 4); finish_press();
    do_go(1'b0);

    // Three-cycle glitch must be rejected
    din = 4'd6;
    key_ent = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 key_ent = 1'b0;
    repeat (2 * DEB + 10) @(posedge clk_sys);
    #1 expect_at(cyc + 1, 1'b0, 1'b0, "glitch_ignored");
    @(posedge clk_sys); #1;

    // Clear and enter coincide in GOT_B: clear wins
    do_ent(8);
    din = 4'd3;
    press(3'b101, c); m_clr(c); finish_press();
    do_go(1'b0);

    // Reset while in CALC1: no result may appear
    do_ent(2); do_ent(3);
    op_sub = 1'b0;
    press(3'b010, c);
    k = 0;
    while (cyc < c + int'(DEB) + 4 && k < 50) begin
      @(posedge clk_sys); #1;
      k++;
    end
    rst = 1'b1;
    {key_clr, key_go, key_ent} = 3'b000;
    m_zero();
    expect_at(cyc, 1'b0, 1'b0, "rst_in_calc1");
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b0;
    expect_at(cyc + 6, 1'b0, 1'b0, "no_partial_result");
    repeat (8) @(posedge clk_sys);
    #1;

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5)      do_ent($urandom_range(0, 11));
      else if (k < 9) do_go(1'($urandom_range(0, 1)));
      else            do_clr();
    end

    do_clr();
    do_ent(9); do_ent(9); do_go(1'b0);
`ifdef BCD_CALC_TIMEOUT_EN
    expect_at(last_show + int'(TMO) - 1, 1'b0, 1'b0, "timeout_still_held");
    m_zero();
    expect_at(last_show + int'(TMO) + 1, 1'b0, 1'b0, "timeout_cleared");
    while (cyc < last_show + int'(TMO) + 4) begin
      @(posedge clk_sys); #1;
    end
`else
    expect_at(last_show + 200, 1'b0, 1'b0, "show_held");
    while (cyc < last_show + 203) begin
      @(posedge clk_sys); #1;
    end
`endif

    k = 0;
    while (sb.size() > 0 && k < 300) begin
      @(posedge clk_sys); #1;
      k++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: check for cycle %0d never reached (now %0d)", e.name, e.at, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
